arb_out_buffer: RTL and testbench

//  Elastic buffer between the rrp_arbiter output (ARB_WRITE_OUT/ARB_DATA_OUT/ARB_READY_OUT) and the external readout FIFO.

---
 rtl/daq_stream_pkg.sv | 13 +
 rtl/arb_out_buffer_if.sv | 28 ++
 rtl/arb_out_buffer_ram.sv | 34 +++
 rtl/arb_out_buffer.sv | 107 ++++++++++
 tb/tb_arb_out_buffer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/daq_stream_pkg.sv
// rtl/daq_stream_pkg.sv - shared widths and helpers for the DAQ readout stream blocks
package daq_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int LOST_CNT_W     = 16;
    localparam int WORD_CNT_W     = 32;

    // Saturating increment for the lost-word counter; sticks at all-ones.
    function automatic logic [LOST_CNT_W-1:0] lost_cnt_inc(input logic [LOST_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/arb_out_buffer_if.sv
// rtl/arb_out_buffer_if.sv - arbiter-side and FIFO-side stream signals of the output buffer
interface arb_out_buffer_if
    import daq_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  IN_WRITE;
    logic [DATA_WIDTH-1:0] IN_DATA;
    logic                  IN_READY;
    logic                  OUT_WRITE;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_FULL;
    logic                  OUT_NEAR_FULL;

    // Environment: arbiter writes in, external FIFO reports its fill state.
    modport master (
        output IN_WRITE, IN_DATA, OUT_FULL, OUT_NEAR_FULL,
        input  IN_READY, OUT_WRITE, OUT_DATA
    );

    // The buffer itself.
    modport slave (
        input  IN_WRITE, IN_DATA, OUT_FULL, OUT_NEAR_FULL,
        output IN_READY, OUT_WRITE, OUT_DATA
    );

endinterface

// File: rtl/arb_out_buffer_ram.sv
// rtl/arb_out_buffer_ram.sv - DEPTH x DATA_WIDTH storage, one write port, one registered read port
module arb_out_buffer_ram #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port returns the old entry when the same address is written this edge.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/arb_out_buffer.sv
// rtl/arb_out_buffer.sv - elastic buffer between the round-robin arbiter and the readout FIFO
module arb_out_buffer
    import daq_stream_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int MARGIN     = 2,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST_N,
    arb_out_buffer_if.slave          bus,
    input  logic                     CLR_CNT,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic [WORD_CNT_W-1:0]    WORD_CNT,
    output logic [LOST_CNT_W-1:0]    LOST_CNT,
    output logic                     OVERFLOW
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t                  wr_ptr_q, wr_ptr_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  level, level_d;
    logic                  pop, push, drop;
    logic                  out_write_q, out_write_d;
    logic                  in_ready_q, in_ready_d;
    logic                  data_seen_q, data_seen_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [LOST_CNT_W-1:0] lost_cnt_q, lost_cnt_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Occupancy and the per-cycle push/pop/drop decisions.
    always_comb begin
        level = wr_ptr_q - rd_ptr_q;
        pop   = (level != '0) && !bus.OUT_FULL;
        push  = bus.IN_WRITE && ((level < ptr_t'(DEPTH)) || pop);
        drop  = bus.IN_WRITE && !push;
    end

    // Next-state for pointers, registered outputs, ready and status counters.
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = wr_ptr_d - rd_ptr_d;
        out_write_d = pop;
        // OUT_DATA reads 0 until the RAM output register has been loaded once.
        data_seen_d = data_seen_q | pop;
        // Margin absorbs the one cycle the arbiter needs to see READY fall.
        in_ready_d  = !bus.OUT_NEAR_FULL && ((ptr_t'(DEPTH) - level_d) > ptr_t'(MARGIN));

        word_cnt_d  = out_write_q ? word_cnt_q + 1'b1 : word_cnt_q;
        lost_cnt_d  = drop ? lost_cnt_inc(lost_cnt_q) : lost_cnt_q;
        overflow_d  = overflow_q | drop;
        if (CLR_CNT) begin
            word_cnt_d = '0;
            lost_cnt_d = '0;
            overflow_d = 1'b0;
        end
    end

    // State registers; buffered words are discarded by clearing the pointers.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_write_q <= 1'b0;
            in_ready_q  <= 1'b0;
            data_seen_q <= 1'b0;
            word_cnt_q  <= '0;
            lost_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_write_q <= out_write_d;
            in_ready_q  <= in_ready_d;
            data_seen_q <= data_seen_d;
            word_cnt_q  <= word_cnt_d;
            lost_cnt_q  <= lost_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    arb_out_buffer_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (BUS_CLK),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (bus.IN_DATA),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rdata)
    );

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_WRITE = out_write_q;
    assign bus.OUT_DATA  = data_seen_q ? ram_rdata : '0;
    assign LEVEL         = level;
    assign WORD_CNT      = word_cnt_q;
    assign LOST_CNT      = lost_cnt_q;
    assign OVERFLOW      = overflow_q;

endmodule

// File: tb/tb_arb_out_buffer.sv
// tb/tb_arb_out_buffer.sv - self-checking bench for arb_out_buffer against a queue model
module tb_arb_out_buffer;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;
    localparam int DW     = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [4:0]  level;
    logic [31:0] word_cnt;
    logic [15:0] lost_cnt;
    logic        overflow;

    arb_out_buffer_if #(.DATA_WIDTH(DW)) bus ();

    arb_out_buffer #(
        .DEPTH      (DEPTH),
        .MARGIN     (MARGIN),
        .DATA_WIDTH (DW)
    ) dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .bus       (bus),
        .CLR_CNT   (clr),
        .LEVEL     (level),
        .WORD_CNT  (word_cnt),
        .LOST_CNT  (lost_cnt),
        .OVERFLOW  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] fifo[$];
    logic        m_ow;
    logic [31:0] m_od;
    logic        m_rdy;
    logic [31:0] m_wc;
    logic [15:0] m_lc;
    logic        m_ov;

    logic [31:0] out_log[$];
    logic [31:0] sent[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: advance the model from the current inputs, clock the DUT, compare.
    task automatic tick();
        bit pop, push, drop;
        if (!rst_n) begin
            fifo.delete();
            m_ow = 0; m_od = 0; m_rdy = 0; m_wc = 0; m_lc = 0; m_ov = 0;
        end else begin
            pop  = (fifo.size() != 0) && !bus.OUT_FULL;
            push = bus.IN_WRITE && ((fifo.size() < DEPTH) || pop);
            drop = bus.IN_WRITE && !push;
            if (m_ow) m_wc = m_wc + 1;
            if (pop) m_od = fifo.pop_front();
            m_ow = pop;
            if (push) fifo.push_back(bus.IN_DATA);
            if (drop) begin
                if (m_lc != 16'hFFFF) m_lc = m_lc + 1;
                m_ov = 1;
            end
            if (clr) begin
                m_wc = 0; m_lc = 0; m_ov = 0;
            end
            m_rdy = !bus.OUT_NEAR_FULL && ((DEPTH - fifo.size()) > MARGIN);
        end
        @(posedge clk);
        #1;
        check("out_write", 64'(bus.OUT_WRITE), 64'(m_ow));
        check("out_data",  64'(bus.OUT_DATA),  64'(m_od));
        check("level",     64'(level),         64'(fifo.size()));
        check("in_ready",  64'(bus.IN_READY),  64'(m_rdy));
        check("word_cnt",  64'(word_cnt),      64'(m_wc));
        check("lost_cnt",  64'(lost_cnt),      64'(m_lc));
        check("overflow",  64'(overflow),      64'(m_ov));
        if (bus.OUT_WRITE === 1'b1) out_log.push_back(bus.OUT_DATA);
    endtask

    task automatic drive_idle();
        bus.IN_WRITE = 0;
        bus.IN_DATA  = '0;
        clr          = 0;
    endtask

    initial begin
        int peak;
        int fall_lvl;
        int base;

        rst_n = 0;
        drive_idle();
        bus.OUT_FULL = 0;
        bus.OUT_NEAR_FULL = 0;
        tick();
        tick();
        check("rst_level", 64'(level), 64'd0);
        check("rst_ready", 64'(bus.IN_READY), 64'd0);
        rst_n = 1;

        // Latency: write in cycle 10, out in cycle 12
        for (int i = 0; i < 9; i++) tick();
        bus.IN_WRITE = 1;
        bus.IN_DATA  = 32'hA5A5_0001;
        tick();
        drive_idle();
        check("t1_c11_write", 64'(bus.OUT_WRITE), 64'd0);
        tick();
        check("t1_c12_write", 64'(bus.OUT_WRITE), 64'd1);
        check("t1_c12_data",  64'(bus.OUT_DATA),  64'hA5A5_0001);
        tick();
        check("t1_level", 64'(level), 64'd0);
        check("t1_wcnt",  64'(word_cnt), 64'd1);

        // Back-pressure with a well-behaved arbiter
        out_log.delete();
        sent.delete();
        bus.OUT_FULL = 1;
        peak = 0;
        fall_lvl = -1;
        for (int c = 0; c < 60; c++) begin
            if (bus.IN_READY && sent.size() < 20) begin
                bus.IN_WRITE = 1;
                bus.IN_DATA  = $urandom;
                sent.push_back(bus.IN_DATA);
            end else begin
                drive_idle();
            end
            tick();
            if (int'(level) > peak) peak = int'(level);
            if (fall_lvl < 0 && !bus.IN_READY) fall_lvl = int'(level);
        end
        check("t2_fall_level", 64'(fall_lvl), 64'(DEPTH - MARGIN));
        check("t2_peak_le15",  64'(peak <= 15), 64'd1);
        bus.OUT_FULL = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.IN_READY && sent.size() < 20) begin
                bus.IN_WRITE = 1;
                bus.IN_DATA  = $urandom;
                sent.push_back(bus.IN_DATA);
            end else begin
                drive_idle();
            end
            tick();
            if (int'(level) > peak) peak = int'(level);
        end
        check("t2_peak_final", 64'(peak <= 15), 64'd1);
        check("t2_overflow", 64'(overflow), 64'd0);
        check("t2_count", 64'(out_log.size()), 64'd20);
        for (int i = 0; i < 20 && i < out_log.size(); i++)
            check("t2_order", 64'(out_log[i]), 64'(sent[i]));

        // Overflow with a misbehaving arbiter, then counter clear
        bus.OUT_FULL = 1;
        for (int i = 0; i < 18; i++) begin
            bus.IN_WRITE = 1;
            bus.IN_DATA  = 32'h3000_0000 + i;
            tick();
        end
        drive_idle();
        tick();
        check("t3_level", 64'(level), 64'd16);
        check("t3_lost",  64'(lost_cnt), 64'd2);
        check("t3_ovf",   64'(overflow), 64'd1);
        clr = 1;
        tick();
        clr = 0;
        check("t3_clr_wcnt", 64'(word_cnt), 64'd0);
        check("t3_clr_lost", 64'(lost_cnt), 64'd0);
        check("t3_clr_ovf",  64'(overflow), 64'd0);
        check("t3_clr_level", 64'(level), 64'd16);

        // Full buffer with simultaneous push and pop
        bus.OUT_FULL = 0;
        for (int i = 0; i < 12; i++) begin
            bus.IN_WRITE = 1;
            bus.IN_DATA  = 32'h4000_0000 + i;
            tick();
            check("t4_level", 64'(level), 64'd16);
        end
        drive_idle();
        check("t4_lost", 64'(lost_cnt), 64'd0);
        for (int i = 0; i < 20; i++) tick();

        // Near full: ready drops, pops continue
        bus.OUT_NEAR_FULL = 1;
        tick();
        check("t5_ready", 64'(bus.IN_READY), 64'd0);
        base = out_log.size();
        for (int i = 0; i < 3; i++) begin
            bus.IN_WRITE = 1;
            bus.IN_DATA  = 32'h5000_0000 + i;
            tick();
        end
        drive_idle();
        for (int i = 0; i < 6; i++) tick();
        check("t5_pops", 64'(out_log.size() - base), 64'd3);
        bus.OUT_NEAR_FULL = 0;
        tick();

        // Reset mid-stream
        bus.OUT_FULL = 1;
        for (int i = 0; i < 8; i++) begin
            bus.IN_WRITE = 1;
            bus.IN_DATA  = 32'h6000_0000 + i;
            tick();
        end
        drive_idle();
        rst_n = 0;
        tick();
        check("t6_level", 64'(level), 64'd0);
        check("t6_write", 64'(bus.OUT_WRITE), 64'd0);
        check("t6_wcnt",  64'(word_cnt), 64'd0);
        check("t6_ready", 64'(bus.IN_READY), 64'd0);
        rst_n = 1;
        bus.OUT_FULL = 0;
        tick();
        check("t6_ready_up", 64'(bus.IN_READY), 64'd1);
        base = out_log.size();
        for (int i = 0; i < 6; i++) tick();
        check("t6_no_stale", 64'(out_log.size() - base), 64'd0);

        // Randomized traffic, mostly honouring ready
        for (int c = 0; c < 3000; c++) begin
            bus.OUT_FULL      = ($urandom % 4) == 0;
            bus.OUT_NEAR_FULL = ($urandom % 8) == 0;
            clr               = ($urandom % 64) == 0;
            bus.IN_DATA       = $urandom;
            if (($urandom % 10) == 0) bus.IN_WRITE = $urandom % 2;
            else                      bus.IN_WRITE = bus.IN_READY && ($urandom % 3 != 0);
            tick();
        end
        drive_idle();
        bus.OUT_FULL = 0;
        bus.OUT_NEAR_FULL = 0;
        for (int i = 0; i < 20; i++) tick();
        check("final_level", 64'(level), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
